divider_16bit: RTL

Sequential fixed-point divider, the inverse of our 16-bit Q-format multiplier in the ODE datapath. Operands and result use the same word format: bits [15:13] are an unsigned scale factor `s` (number of fractional bits), and bits [12:0] are a signed two's-complement mantissa `m`, so value = m / 2^s. The block computes dividend ÷ divisor with a radix-2 restoring iteration. It presents a start/busy/done handshake to the solver control FSM.

---
 rtl/fxp_pkg.sv | 28 ++
 rtl/divider_16bit_udiv_step.sv | 20 ++
 rtl/divider_16bit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// Shared Q-format definitions for the fixed-point multiplier/divider pair.
// A word is {scale[2:0], mantissa[12:0]}, value = mantissa / 2^scale.
package fxp_pkg;

  localparam int SF_W    = 3;
  localparam int MANT_W  = 13;
  localparam int SHIFT_W = 14;                 // largest pre-shift of the dividend
  localparam int Q_W     = MANT_W + SHIFT_W;   // shifted-dividend / quotient width

  localparam logic [MANT_W-1:0] MANT_MAX = 13'h0FFF;
  localparam logic [MANT_W-1:0] MANT_MIN = 13'h1000;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} div_state_t;

  typedef struct packed {
    logic        [SF_W-1:0] sf;
    logic signed [15:0]     mant;   // mantissa sign-extended to 16 bits
  } qword_t;

  // Split a Q-format word into its scale and sign-extended mantissa.
  function automatic qword_t q_unpack(input logic [15:0] w);
    qword_t r;
    r.sf   = w[15:13];
    r.mant = {{3{w[12]}}, w[12:0]};
    return r;
  endfunction

endpackage

// File: rtl/divider_16bit_udiv_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module udiv_step
  import fxp_pkg::*;
(
  input  logic [MANT_W:0]   i_rem,
  input  logic [MANT_W-1:0] i_dvs,
  input  logic              i_bit,
  output logic [MANT_W:0]   o_rem,
  output logic              o_qbit
);

  logic [MANT_W+1:0] w_trial;

  assign w_trial = {i_rem, i_bit};
  assign o_qbit  = (w_trial >= {2'b00, i_dvs});
  // The remainder always stays below the divisor, so 14 bits hold it.
  assign o_rem   = o_qbit ? (w_trial[MANT_W:0] - {1'b0, i_dvs}) : w_trial[MANT_W:0];

endmodule

// File: rtl/divider_16bit.sv
// Sequential Q-format divider: 27-step radix-2 restoring division of the
// pre-shifted dividend magnitude, then sign restore and saturation.
module divider_16bit #(
  parameter int WIDTH = 16,
  parameter int SF_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             div_by_zero
);
  import fxp_pkg::*;

  div_state_t r_state, w_next;

  logic [WIDTH-1:0]  r_dvd, r_dvs;
  logic [SF_W-1:0]   r_so;
  logic              r_neg, r_neg_a;
  logic [MANT_W-1:0] r_mag_b;
  logic [Q_W-1:0]    r_q;
  logic [MANT_W:0]   r_rem;
  logic [4:0]        r_cnt;
  logic              r_ld2;
  logic [WIDTH-1:0]  r_out;
  logic              r_ovf, r_dz;

  qword_t            w_ua, w_ub;
  logic [SF_W-1:0]   w_so;
  logic [3:0]        w_k;
  logic [MANT_W-1:0] w_mag_a;
  logic [Q_W-1:0]    w_sh;
  logic              w_b_zero;
  logic [MANT_W:0]   w_rem_nx;
  logic              w_qbit;
  logic [Q_W-1:0]    w_q_fin;
  logic [MANT_W:0]   w_sat;

  // Magnitude of a sign-extended mantissa; -4096 maps to 13'h1000.
  function automatic logic [MANT_W-1:0] f_mag(input logic signed [15:0] m);
    return MANT_W'(m[15] ? (16'd0 - m) : m);
  endfunction

  // Apply sign to the unsigned quotient and clamp to the mantissa range.
  // Returns {overflow, mantissa}; a zero quotient is always +0.
  function automatic logic [MANT_W:0] f_sat(input logic [Q_W-1:0] q, input logic neg);
    if (!neg) begin
      if (q > Q_W'(4095)) return {1'b1, MANT_MAX};
      return {1'b0, q[MANT_W-1:0]};
    end
    if (q > Q_W'(4096)) return {1'b1, MANT_MIN};
    return {1'b0, MANT_W'(13'd0 - q[MANT_W-1:0])};
  endfunction

  assign w_ua     = q_unpack(r_dvd);
  assign w_ub     = q_unpack(r_dvs);
  assign w_so     = (w_ua.sf > w_ub.sf) ? w_ua.sf : w_ub.sf;
  assign w_k      = 4'(w_so) - 4'(w_ua.sf) + 4'(w_ub.sf);
  assign w_mag_a  = f_mag(w_ua.mant);
  assign w_sh     = {{SHIFT_W{1'b0}}, w_mag_a} << w_k;
  assign w_b_zero = (w_ub.mant == 16'sd0);
  assign w_q_fin  = {r_q[Q_W-2:0], w_qbit};
  assign w_sat    = f_sat(w_q_fin, r_neg);

  udiv_step u_step (
    .i_rem  (r_rem),
    .i_dvs  (r_mag_b),
    .i_bit  (r_q[Q_W-1]),
    .o_rem  (w_rem_nx),
    .o_qbit (w_qbit)
  );

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        busy = 1'b1;
        // A zero divisor spends a second LOAD cycle to register the
        // saturated result, then skips the iteration entirely.
        if (r_ld2)         w_next = DONE;
        else if (!w_b_zero) w_next = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (r_cnt == 5'd26) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Control state, step counter and registered results (reset applies here).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ld2   <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        LOAD: begin
          r_cnt <= '0;
          r_ld2 <= !r_ld2 && w_b_zero;
          if (r_ld2) begin
            r_out <= {r_so, (r_neg_a ? MANT_MIN : MANT_MAX)};
            r_ovf <= 1'b1;
            r_dz  <= 1'b1;
          end
        end
        ITER: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd26) begin
            r_out <= {r_so, w_sat[MANT_W-1:0]};
            r_ovf <= w_sat[MANT_W];
            r_dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand capture, LOAD setup, one quotient bit per ITER cycle.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_dvd <= dividend;
      r_dvs <= divisor;
    end
    if (r_state == LOAD && !r_ld2) begin
      r_so    <= w_so;
      r_neg   <= w_ua.mant[15] ^ w_ub.mant[15];
      r_neg_a <= w_ua.mant[15];
      r_mag_b <= f_mag(w_ub.mant);
      r_q     <= w_sh;
      r_rem   <= '0;
    end
    if (r_state == ITER) begin
      r_q   <= w_q_fin;
      r_rem <= w_rem_nx;
    end
  end

  assign out         = r_out;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dz;

endmodule
